// File: rtl/uart_cmd_scheduler.sv
// rtl/uart_cmd_scheduler.sv - request FIFO and one-outstanding command sequencer for the UART register master
module uart_cmd_scheduler #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  cmd_valid,
  output logic [CMD_WIDTH-1:0]  cmd_data,
  input  logic                  cmd_ready,
  input  logic                  read_valid,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, TX_WAIT, RD_WAIT, RESP} state_t;

  state_t                 state, state_next;
  logic [CMD_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW:0]            wr_ptr, rd_ptr;
  logic                   fifo_empty, fifo_full, push, pop, fire;
  logic                   frame_done, tmo_hit, load_resp;
  logic [CMD_WIDTH-1:0]   head;
  logic                   hold_write, rd_latched;
  logic [DATA_WIDTH-1:0]  rd_latch_data;
  logic [CW-1:0]          tmo_cnt, tmo_inc;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign req_ready  = ~fifo_full;
  assign push       = req_valid && req_ready;
  assign head       = fifo_mem[rd_ptr[PW-1:0]];
  assign resp_valid = (state == RESP);

  // The pulse cycle is the first TX_WAIT cycle; cmd_ready there is still the pre-frame idle level.
  assign frame_done = (state == TX_WAIT) && !cmd_valid && cmd_ready;
  assign tmo_inc    = tmo_cnt + CW'(1);
  assign tmo_hit    = (tmo_inc == CW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {req_write, req_addr, req_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty && !resp_valid) state_next = ISSUE;
      ISSUE:   if (cmd_ready) state_next = TX_WAIT;
      TX_WAIT: if (frame_done) state_next = (hold_write || rd_latched || read_valid) ? RESP : RD_WAIT;
      RD_WAIT: if (read_valid || tmo_hit) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop       = (state == IDLE) && (state_next == ISSUE);
    fire      = (state == ISSUE) && cmd_ready;
    load_resp = (state != RESP) && (state_next == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_write    <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_data      <= '0;
      rd_latched    <= 1'b0;
      rd_latch_data <= '0;
      tmo_cnt       <= '0;
      resp_write    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      cmd_valid <= fire;
      if (pop) begin
        hold_write <= head[CMD_WIDTH-1];
        cmd_data   <= head[CMD_WIDTH-1] ? head
                    : {head[CMD_WIDTH-1 -: ADDR_WIDTH+1], {DATA_WIDTH{1'b0}}};
        rd_latched <= 1'b0;
      end else if (state == TX_WAIT && read_valid && !rd_latched) begin
        rd_latched    <= 1'b1;
        rd_latch_data <= read_data;
      end
      if (frame_done)            tmo_cnt <= '0;
      else if (state == RD_WAIT) tmo_cnt <= tmo_inc;
      if (load_resp) begin
        resp_write <= hold_write;
        if (hold_write) begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end else if (state == TX_WAIT) begin
          resp_rdata <= rd_latched ? rd_latch_data : read_data;
          resp_err   <= 1'b0;
        end else if (read_valid) begin
          // A reply landing on the timeout cycle still counts as data.
          resp_rdata <= read_data;
          resp_err   <= 1'b0;
        end else begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// tb/tb_uart_cmd_scheduler.sv - scoreboard bench for uart_cmd_scheduler with a cycle-level UART model
module tb_uart_cmd_scheduler;

  localparam int RD_TIMEOUT = 20000;
  localparam int PRE_BUSY   = 9548;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [6:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_data;
  logic        read_valid;
  logic [7:0]  read_data;
  logic        resp_valid, resp_ready, resp_write, resp_err;
  logic [7:0]  resp_rdata;

  uart_cmd_scheduler #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .read_valid(read_valid), .read_data(read_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic w; logic [7:0] rdata; logic err; int lat; } resp_t;
  typedef struct { logic [15:0] cmd; int frame; int reply; logic [7:0] rdata; } cmd_t;

  resp_t exp_q[$];
  cmd_t  cmd_q[$];

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int rise_cyc = 0;
  int stray_req = 0;
  int stray_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // UART model: reply < 0: -1 none, -2 mid-frame; otherwise cycles after cmd_ready rises.
  cmd_t cur;
  int   m_busy = PRE_BUSY;
  int   m_cd = -1;
  bit   m_drop = 0;
  bit   m_in_frame = 0;

  initial begin : uart_model
    cmd_ready  = 1'b0;
    read_valid = 1'b0;
    read_data  = 8'h00;
    cur = '{cmd: 16'h0, frame: 0, reply: -1, rdata: 8'h00};
    forever begin
      @(posedge clk); #1;
      read_valid = 1'b0;
      if (rst) begin
        m_cd = -1;
        m_drop = 0;
      end
      if (m_drop) begin
        cmd_ready = 1'b0;
        m_busy = cur.frame;
        m_drop = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_in_frame && cur.reply == -2 && m_busy == cur.frame / 2) begin
          read_valid = 1'b1;
          read_data  = cur.rdata;
        end
        if (m_busy == 0) begin
          cmd_ready = 1'b1;
          rise_cyc = cyc;
          if (m_in_frame && cur.reply >= 0) m_cd = cur.reply;
          m_in_frame = 0;
        end
      end
      if (m_cd == 0) begin
        read_valid = 1'b1;
        read_data  = cur.rdata;
        m_cd = -1;
      end else if (m_cd > 0) begin
        m_cd--;
      end
      if (stray_done != stray_req) begin
        read_valid = 1'b1;
        read_data  = 8'h11;
        stray_done++;
      end
      if (cmd_valid && !rst) begin
        pulses++;
        pulse_cyc = cyc;
        check("pulse_rdy", cmd_ready, 1);
        if (cmd_q.size() == 0) begin
          check("cmd_extra", 1, 0);
        end else begin
          cur = cmd_q.pop_front();
          check("cmd_data", cmd_data, cur.cmd);
          m_drop = 1;
          m_in_frame = 1;
        end
      end
    end
  end

  initial begin : resp_mon
    bit    prev;
    int    first;
    resp_t e;
    prev = 0;
    first = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 0;
        continue;
      end
      if (resp_valid && !prev) first = cyc;
      prev = resp_valid;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_write", resp_write, e.w);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", resp_err, e.err);
          check("resp_lat", first - rise_cyc, e.lat);
        end
      end
    end
  end

  task automatic push_req(input logic w, input logic [6:0] a, input logic [7:0] d, output int acc);
    logic ok;
    int   n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    check("push_accepted", ok, 1);
    acc = cyc;
  endtask

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                      input int frame, input int reply, input logic [7:0] rd, output int acc);
    cmd_t  c;
    resp_t e;
    c.cmd = {w, a, (w ? d : 8'h00)};
    c.frame = frame;
    c.reply = reply;
    c.rdata = rd;
    e.w = w;
    if (w) begin
      e.rdata = 8'h00; e.err = 1'b0; e.lat = 1;
    end else if (reply == -2) begin
      e.rdata = rd; e.err = 1'b0; e.lat = 1;
    end else if (reply >= 0 && reply <= RD_TIMEOUT - 1) begin
      e.rdata = rd; e.err = 1'b0; e.lat = reply + 1;
    end else begin
      e.rdata = 8'h00; e.err = 1'b1; e.lat = RD_TIMEOUT;
    end
    cmd_q.push_back(c);
    exp_q.push_back(e);
    push_req(w, a, d, acc);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_q.size() != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    check(tag, n < bound, 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int acc, acc1, p0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 7'h00; req_wdata = 8'h00;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_data", cmd_data, 16'h0000);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_write", resp_write, 0);
    check("rst_resp_rdata", resp_rdata, 8'h00);
    check("rst_resp_err", resp_err, 0);
    rst = 1'b0;

    // Write issued while the UART is still busy from before.
    send(1'b1, 7'h15, 8'hA5, 20, -1, 8'h00, acc);
    wait_done("t1_done", 12000);
    check("t1_pulses", pulses, 1);

    send(1'b0, 7'h22, 8'h00, 20, 500, 8'h3C, acc);
    wait_done("t2_done", 2000);
    check("t2_issue_lat", pulse_cyc - acc, 2);

    send(1'b0, 7'h7F, 8'h00, 20, -1, 8'h00, acc);
    wait_done("t3_done", 25000);
    p0 = pulses;
    stray_req++;
    repeat (30) @(posedge clk);
    #1;
    check("t3_stray_resp", resp_valid, 0);
    check("t3_stray_pulse", pulses - p0, 0);
    check("t3_stray_ready", req_ready, 1);

    // Five back-to-back requests with the host stalling responses.
    resp_ready = 1'b0;
    p0 = pulses;
    send(1'b1, 7'h01, 8'h10, 10, -1, 8'h00, acc1);
    send(1'b0, 7'h02, 8'h00, 10, 3, 8'h5A, acc);
    send(1'b1, 7'h03, 8'h30, 10, -1, 8'h00, acc);
    send(1'b0, 7'h04, 8'h00, 10, 3, 8'hC3, acc);
    send(1'b1, 7'h05, 8'h50, 10, -1, 8'h00, acc);
    check("t4_back_to_back", acc - acc1, 4);
    check("t4_full", req_ready, 0);
    repeat (100) @(posedge clk);
    #1;
    check("t4_one_issue", pulses - p0, 1);
    check("t4_resp_hold", resp_valid, 1);
    check("t4_hold_full", req_ready, 0);
    resp_ready = 1'b1;
    wait_done("t4_done", 2000);
    check("t4_all_issued", pulses - p0, 5);

    send(1'b0, 7'h33, 8'h00, 10, RD_TIMEOUT - 1, 8'h77, acc);
    wait_done("t5a_done", 25000);
    send(1'b0, 7'h44, 8'h00, 20, -2, 8'h99, acc);
    wait_done("t5b_done", 2000);

    // Reset while a read waits with three more requests queued.
    send(1'b0, 7'h55, 8'h00, 10, -1, 8'h00, acc);
    repeat (40) @(posedge clk);
    #1;
    send(1'b1, 7'h61, 8'h01, 10, -1, 8'h00, acc);
    send(1'b1, 7'h62, 8'h02, 10, -1, 8'h00, acc);
    send(1'b1, 7'h63, 8'h03, 10, -1, 8'h00, acc);
    check("t6_queued_full", req_ready, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_req_ready", req_ready, 1);
    check("t6_cmd_valid", cmd_valid, 0);
    check("t6_cmd_data", cmd_data, 16'h0000);
    check("t6_resp_valid", resp_valid, 0);
    check("t6_resp_write", resp_write, 0);
    check("t6_resp_rdata", resp_rdata, 8'h00);
    check("t6_resp_err", resp_err, 0);
    exp_q.delete();
    cmd_q.delete();
    p0 = pulses;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("t6_no_issue", pulses - p0, 0);
    check("t6_no_resp", resp_valid, 0);
    check("t6_ready_after", req_ready, 1);
    check("final_exp_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
